pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Combines the hazard-detect signal, the ID-stage branch decision and the MEM-stage SRAM handshake into per-stage freeze, flush and bubble controls.
- Tracks SRAM wait time with a watchdog and keeps saturating performance counters.
- Sits beside the hazard unit; drives the PC register, IF/ID, ID/EXE, EXE/MEM and MEM/WB enables and clears.

---
 rtl/pipeline_stall_controller_pkg.sv | 10 +
 rtl/pipeline_stall_controller_sat_counter.sv | 15 +
 rtl/pipeline_stall_controller.sv | 80 ++++++++
 tb/tb_pipeline_stall_controller.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// pipeline_stall_controller_pkg: shared state encoding and default sizing for the stall controller.
package pipeline_stall_controller_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  always_comb q_d = (inc && !(&q_q)) ? q_q + W'(1) : q_q;
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: prioritised freeze/flush/bubble control with SRAM watchdog and perf counters.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             br_taken,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_back,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);
  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            timeout_q, timeout_d;
  logic            mem_busy, err, halt;
  assign mem_busy = (mem_r_en | mem_w_en) & ~sram_ready;
  assign err      = state_q == ERR;
  assign halt     = err | mem_busy;
  // A hazard only bubbles when the back end is moving; a branch only flushes with valid operands.
  always_comb begin
    freeze_back   = halt;
    freeze_pc     = halt | hazard_detected;
    freeze_if_id  = halt | hazard_detected;
    bubble_id_exe = ~halt & hazard_detected;
    flush_if_id   = ~halt & ~hazard_detected & br_taken;
  end
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (state_q == RUN) begin
      if (mem_busy) begin
        state_d = MEM_WAIT;
        wait_d  = TO_W'(1);
      end
    end else if (state_q == MEM_WAIT) begin
      if (!mem_busy) begin
        state_d = RUN;
        wait_d  = '0;
      end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
        state_d   = ERR;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + TO_W'(1);
      end
    end else if (state_q != ERR) begin
      state_d = RUN;
      wait_d  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
  assign mem_timeout = timeout_q;
  sat_counter #(.W(CNT_W)) u_stall   (.clk(clk), .rst(rst), .inc(bubble_id_exe),   .q(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush   (.clk(clk), .rst(rst), .inc(flush_if_id),     .q(flush_cnt));
  sat_counter #(.W(CNT_W)) u_memwait (.clk(clk), .rst(rst), .inc(mem_busy & ~err), .q(memwait_cnt));
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed checks of priority, FSM, watchdog and counters.
module tb_pipeline_stall_controller;
  logic clk, rst, hazard_detected, br_taken, mem_r_en, mem_w_en, sram_ready;
  logic freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_back, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt, memwait_cnt;
  logic f4_pc, f4_ifid, fl4, bub4, fb4, to4;
  logic [3:0] stall4, flush4, memwait4;
  int total = 0;
  int bad = 0;

  pipeline_stall_controller dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .br_taken(br_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .sram_ready(sram_ready),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .bubble_id_exe(bubble_id_exe), .freeze_back(freeze_back), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  pipeline_stall_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .br_taken(br_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .sram_ready(sram_ready),
    .freeze_pc(f4_pc), .freeze_if_id(f4_ifid), .flush_if_id(fl4),
    .bubble_id_exe(bub4), .freeze_back(fb4), .mem_timeout(to4),
    .stall_cnt(stall4), .flush_cnt(flush4), .memwait_cnt(memwait4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic h, input logic b, input logic r, input logic w, input logic s);
    hazard_detected = h;
    br_taken = b;
    mem_r_en = r;
    mem_w_en = w;
    sram_ready = s;
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_back}, 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    tick();
    set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    tick();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_memwait_cnt", memwait_cnt, 0);
    chk("rst_timeout", mem_timeout, 0);
    set_in(0, 0, 0, 0, 0);
    chk_ctl("rst_ctl_idle", 5'b00000);
    rst = 1'b0;
    tick();
    chk_ctl("run_idle", 5'b00000);
    set_in(1, 1, 0, 0, 0);
    chk_ctl("hazard_c1", 5'b11010);
    tick();
    chk_ctl("hazard_c2", 5'b11010);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("hazard_stall_cnt", stall_cnt, 2);
    chk("hazard_flush_cnt", flush_cnt, 0);
    set_in(0, 1, 0, 0, 0);
    chk_ctl("branch_flush", 5'b00100);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk_ctl("branch_after", 5'b00000);
    chk("branch_flush_cnt", flush_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 1, 0, 0);
      chk_ctl($sformatf("sram_wait_%0d", i), 5'b11001);
      tick();
    end
    set_in(0, 0, 1, 0, 1);
    chk_ctl("sram_ready_cycle", 5'b00000);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("sram_memwait_cnt", memwait_cnt, 3);
    chk("sram_no_bubble", stall_cnt, 2);
    set_in(0, 0, 0, 0, 1);
    chk_ctl("ready_no_access", 5'b00000);
    tick();
    chk("ready_no_access_cnt", memwait_cnt, 3);
    set_in(0, 0, 1, 0, 0);
    for (int i = 0; i < 40; i++) tick();
    set_in(0, 0, 1, 0, 1);
    tick();
    chk("access_a_timeout", mem_timeout, 0);
    chk("access_a_memwait", memwait_cnt, 43);
    set_in(0, 0, 0, 1, 0);
    for (int i = 0; i < 63; i++) tick();
    chk("wd_edge63_timeout", mem_timeout, 0);
    chk_ctl("wd_edge63_ctl", 5'b11001);
    tick();
    chk("wd_edge64_timeout", mem_timeout, 1);
    chk("wd_memwait", memwait_cnt, 107);
    set_in(1, 1, 0, 0, 0);
    chk_ctl("err_halted", 5'b11001);
    for (int i = 0; i < 3; i++) tick();
    chk_ctl("err_still_halted", 5'b11001);
    chk("err_timeout_sticky", mem_timeout, 1);
    chk("err_stall_frozen", stall_cnt, 2);
    chk("err_flush_frozen", flush_cnt, 1);
    chk("err_memwait_frozen", memwait_cnt, 107);
    chk("sat_memwait4", memwait4, 15);
    rst = 1'b1;
    set_in(0, 0, 0, 1, 0);
    tick();
    chk("midrst_timeout", mem_timeout, 0);
    chk("midrst_memwait", memwait_cnt, 0);
    chk_ctl("midrst_busy_freeze", 5'b11001);
    rst = 1'b0;
    tick();
    set_in(0, 0, 0, 0, 0);
    tick();
    chk_ctl("after_rst_idle", 5'b00000);
    chk("after_rst_memwait", memwait_cnt, 1);
    chk("after_rst_timeout", mem_timeout, 0);
    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    set_in(0, 0, 0, 0, 0);
    chk("sat_stall16", stall_cnt, 20);
    chk("sat_stall4", stall4, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
